// File: rtl/latch_ctrl_pkg.sv
// Shared types and defaults for the latch bank write scheduler.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_DW        = 8;
  localparam int unsigned DEF_SETUP_CYC = 1;
  localparam int unsigned DEF_EN_CYC    = 2;
  localparam int unsigned DEF_HOLD_CYC  = 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter holds at most max_len-1, so a single bit suffices for max_len <= 2.
  function automatic int unsigned cnt_width(input int unsigned max_len);
    return (max_len <= 2) ? 1 : $clog2(max_len);
  endfunction

endpackage

// File: rtl/latch_rr_arb.sv
// Combinational NREQ-way arbiter: first requester found searching upward from ptr_i, wrapping.
module latch_rr_arb
  import latch_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] win_o
);

  localparam int unsigned OW = $clog2(NREQ);

  logic          found;
  logic [OW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = OW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = idx;
      end
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write scheduler for a shared latch bank: setup / enable / hold sequencing per write.
// LATCH_CTRL_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
module latch_bank_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned EN_CYC    = DEF_EN_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [DW-1:0]           lat_d,
  output logic                    lat_en
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = cnt_width(max3(SETUP_CYC, EN_CYC, HOLD_CYC));

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   lat_d_q, lat_d_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            lat_en_q, lat_en_d;
  logic            busy_q, busy_d;

  logic [OW-1:0]   arb_ptr;
  logic [NREQ-1:0] arb_gnt;
  logic [OW-1:0]   arb_win;
  logic [DW-1:0]   win_data;

  latch_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (arb_ptr),
    .gnt_o (arb_gnt),
    .win_o (arb_win)
  );

  // One-hot AND-OR data select of the winning requester.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (arb_gnt[i]) win_data = win_data | wdata[i*DW +: DW];
    end
  end

`ifdef LATCH_CTRL_RR_EN
  logic [OW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && |req) begin
      ptr_d = (arb_win == OW'(NREQ - 1)) ? '0 : arb_win + OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`else
  assign arb_ptr = '0;
`endif

  // Next-state and registered-output decode; outputs are derived from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d_d  = lat_d_q;
    owner_d  = owner_q;
    gnt_d    = '0;
    lat_en_d = 1'b0;
    busy_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          lat_d_d = win_data;
          owner_d = arb_win;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ENABLE;
          cnt_d   = CW'(EN_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ENABLE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    lat_en_d = (state_d == ENABLE);
    busy_d   = (state_d != IDLE);
    if (state_d == HOLD && cnt_d == '0) gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lat_d_q  <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      lat_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_d_q  <= lat_d_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      lat_en_q <= lat_en_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign busy   = busy_q;
  assign owner  = owner_q;
  assign lat_d  = lat_d_q;
  assign lat_en = lat_en_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: default-window and swept-window instances share stimulus,
// each checked every cycle against a transaction-position model.
module tb_latch_bank_ctrl;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned OW   = 2;
  localparam int          NI   = 2;
  localparam int unsigned S0 = 1, E0 = 2, H0 = 1;
  localparam int unsigned S1 = 2, E1 = 3, H1 = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;

  logic [NREQ-1:0] gnt_w   [NI];
  logic            busy_w  [NI];
  logic [OW-1:0]   own_w   [NI];
  logic [DW-1:0]   latd_w  [NI];
  logic            laten_w [NI];

  int checks = 0;
  int errors = 0;

  latch_bank_ctrl #(.NREQ(NREQ), .DW(DW), .SETUP_CYC(S0), .EN_CYC(E0), .HOLD_CYC(H0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt_w[0]), .busy(busy_w[0]), .owner(own_w[0]), .lat_d(latd_w[0]), .lat_en(laten_w[0])
  );

  latch_bank_ctrl #(.NREQ(NREQ), .DW(DW), .SETUP_CYC(S1), .EN_CYC(E1), .HOLD_CYC(H1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt_w[1]), .busy(busy_w[1]), .owner(own_w[1]), .lat_d(latd_w[1]), .lat_en(laten_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int unsigned ms(input int i);
    return (i == 0) ? S0 : S1;
  endfunction
  function automatic int unsigned me(input int i);
    return (i == 0) ? E0 : E1;
  endfunction
  function automatic int unsigned mper(input int i);
    return (i == 0) ? (S0 + E0 + H0) : (S1 + E1 + H1);
  endfunction

  // First requesting index at or after p, wrapping.
  function automatic int unsigned m_arb(input logic [NREQ-1:0] r, input int unsigned p);
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (r[OW'((p + j) % NREQ)]) return (p + j) % NREQ;
    end
    return 0;
  endfunction

  // mk = position within current write (0 idle, 1..period busy); period is the gnt cycle.
  int unsigned    mk   [NI];
  int unsigned    mptr [NI];
  int unsigned    mown [NI];
  logic [DW-1:0]  mdat [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      mk[i] = 0; mptr[i] = 0; mown[i] = 0; mdat[i] = '0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        mk[i] <= 0; mptr[i] <= 0; mown[i] <= 0; mdat[i] <= '0;
      end else if (mk[i] == 0) begin
        if (req != '0) begin
          mown[i] <= m_arb(req, mptr[i]);
          mdat[i] <= wdata[m_arb(req, mptr[i])*DW +: DW];
`ifdef LATCH_CTRL_RR_EN
          mptr[i] <= (m_arb(req, mptr[i]) + 1) % NREQ;
`endif
          mk[i] <= 1;
        end
      end else begin
        mk[i] <= (mk[i] == mper(i)) ? 0 : mk[i] + 1;
      end
    end
  end

  function automatic logic [15:0] exp_vec(input int i);
    logic [NREQ-1:0] g;
    logic            en;
    g  = (mk[i] == mper(i)) ? NREQ'(1) << mown[i] : '0;
    en = (mk[i] > ms(i)) && (mk[i] <= ms(i) + me(i));
    return {g, (mk[i] != 0), OW'(mown[i]), mdat[i], en};
  endfunction

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("model_inst%0d {gnt,busy,owner,lat_d,lat_en}", i),
          32'({gnt_w[i], busy_w[i], own_w[i], latd_w[i], laten_w[i]}), 32'(exp_vec(i)));
    end
  end

  // ---------------- directed tests ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_lat_en", 32'(laten_w[0]), 32'd0);
      chk("rst_busy",   32'(busy_w[0]),  32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_lat_en", 32'(laten_w[0]), 32'd0);
      chk("idle_lat_d",  32'(latd_w[0]),  32'h00);
      chk("idle_busy",   32'(busy_w[0]),  32'd0);
      chk("idle_gnt",    32'(gnt_w[0]),   32'd0);
    end
  endtask

  task automatic single_write();
    int en1;
    int g1_at;
    en1 = 0; g1_at = 0;
    do_reset();
    req   = 4'b0100;
    wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 4) chk($sformatf("sw_lat_d_c%0d", c), 32'(latd_w[0]), 32'hA5);
      chk($sformatf("sw_lat_en_c%0d", c), 32'(laten_w[0]), 32'((c == 2) || (c == 3)));
      chk($sformatf("sw_gnt_c%0d", c), 32'(gnt_w[0]), (c == 4) ? 32'h4 : 32'h0);
      chk($sformatf("sw_busy_c%0d", c), 32'(busy_w[0]), 32'(c <= 4));
      if (laten_w[1]) en1++;
      if (gnt_w[1] == 4'b0100) g1_at = c;
      if (c == 4) req = '0;
    end
    chk("sweep_lat_en_cycles", 32'(en1), 32'd3);
    chk("sweep_gnt_cycle", 32'(g1_at), 32'd7);
  endtask

  task automatic dropped_req();
    do_reset();
    req   = 4'b0010;
    wdata = {8'h00, 8'h00, 8'h6E, 8'h00};
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2 || c == 3) chk($sformatf("drop_lat_en_c%0d", c), 32'(laten_w[0]), 32'd1);
      if (c == 2) req = '0;
      if (c == 4) chk("drop_gnt", 32'(gnt_w[0]), 32'h2);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic contention();
    logic [NREQ-1:0] seq [4];
    logic [NREQ-1:0] exp_seq [4];
    int cyc [4];
    int n;
`ifdef LATCH_CTRL_RR_EN
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
`else
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0001;
`endif
    n = 0;
    for (int k = 0; k < 4; k++) begin seq[k] = '0; cyc[k] = 0; end
    do_reset();
    req   = 4'b1011;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (gnt_w[0] != '0 && n < 4) begin
        seq[n] = gnt_w[0];
        cyc[n] = c;
        n++;
      end
    end
    chk("cont_count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_gnt_%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
      chk($sformatf("cont_cycle_%0d", k), 32'(cyc[k]), 32'(4 + 5 * k));
    end
    req = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic mid_reset();
    do_reset();
    req   = 4'b0100;
    wdata = {8'h11, 8'h3C, 8'h22, 8'h33};
    @(negedge clk);
    @(negedge clk);
    chk("mid_lat_en_before", 32'(laten_w[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_lat_en_async", 32'(laten_w[0]), 32'd0);
    chk("mid_busy_async",   32'(busy_w[0]),  32'd0);
    chk("mid_gnt_async",    32'(gnt_w[0]),   32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0101;
    wdata = {8'h00, 8'h77, 8'h00, 8'h5A};
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("post_rst_owner", 32'(own_w[0]), 32'd0);
        chk("post_rst_lat_d", 32'(latd_w[0]), 32'h5A);
      end
      if (c == 4) begin
        chk("post_rst_gnt", 32'(gnt_w[0]), 32'h1);
        req = '0;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic random_phase(input int ncyc);
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      wdata = 32'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    req = '0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    req   = '0;
    wdata = '0;
    #1 rst_n = 1'b0;
    do_reset();
    single_write();
    dropped_req();
    contention();
    mid_reset();
    random_phase(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
